fp_job_sequencer: RTL and testbench

Hardware job initiator for the floating-point compute cores (CORDIC top and similar). It accepts 32-bit IEEE-754 operands from an upstream valid/ready source and presents each one on `core_data`. One cycle later it issues a single-cycle `core_start` pulse, waits for the core's `core_done`, and returns the captured result downstream over valid/ready. An optional watchdog aborts jobs whose core never completes.

---
 rtl/fp_seq_pkg.sv | 16 +
 rtl/fp_seq_if.sv | 40 ++++
 rtl/fp_seq_watchdog.sv | 35 +++
 rtl/fp_job_sequencer.sv | 111 +++++++++++
 tb/tb_fp_job_sequencer.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_seq_pkg.sv
// fp_seq_pkg: shared types and constants for the FP job sequencer.
// Holds the FSM state enum, the quiet-NaN abort word and the data width.
package fp_seq_pkg;

  localparam int FP_DATA_W = 32;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    OUT
  } seq_state_e;

endpackage

// File: rtl/fp_seq_if.sv
// fp_seq_if: upstream, core-side and downstream signals of the sequencer.
// master is the sequencer view, slave is the environment view.
interface fp_seq_if
  import fp_seq_pkg::*;
#(
  parameter int DATA_W = FP_DATA_W
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] core_data;
  logic              core_start;
  logic              core_done;
  logic [DATA_W-1:0] core_result;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_timeout;
  logic              busy;

  modport master (
    input  in_valid, in_data,
    input  core_done, core_result,
    input  out_ready,
    output in_ready, core_data, core_start,
    output out_valid, out_data, out_timeout,
    output busy
  );

  modport slave (
    output in_valid, in_data,
    output core_done, core_result,
    output out_ready,
    input  in_ready, core_data, core_start,
    input  out_valid, out_data, out_timeout,
    input  busy
  );

endinterface

// File: rtl/fp_seq_watchdog.sv
// fp_seq_watchdog: WAIT-cycle counter with clear, increment and expiry.
// expired is high while the count sits at TIMEOUT-1.
module fp_seq_watchdog #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = $clog2(TIMEOUT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/fp_job_sequencer.sv
// fp_job_sequencer: operand -> core start -> result job initiator.
// Optional watchdog abort under FP_SEQ_TIMEOUT_EN.
module fp_job_sequencer
  import fp_seq_pkg::*;
#(
  parameter int DATA_W  = FP_DATA_W,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = $clog2(TIMEOUT)
) (
  input logic      clk,
  input logic      rst_n,
  fp_seq_if.master bus
);

  seq_state_e        state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              core_start_q, core_start_d;
  logic              out_valid_q, out_valid_d;
  logic              out_timeout_q, out_timeout_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] core_data_q, core_data_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              expired;

`ifdef FP_SEQ_TIMEOUT_EN
  fp_seq_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_q == START),
    .inc     ((state_q == WAIT) && !bus.core_done),
    .expired (expired)
  );
`else
  logic [CNT_W-1:0] unused_lim;
  assign unused_lim = CNT_W'(TIMEOUT - 1);
  assign expired    = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    core_data_d   = core_data_q;
    out_data_d    = out_data_q;
    out_timeout_d = out_timeout_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          state_d     = LOAD;
          core_data_d = bus.in_data;
        end
      end
      LOAD:  state_d = START;
      START: state_d = WAIT;
      WAIT: begin
        // a completing core beats the watchdog on the same edge
        if (bus.core_done) begin
          state_d       = OUT;
          out_data_d    = bus.core_result;
          out_timeout_d = 1'b0;
        end else if (expired) begin
          state_d       = OUT;
          out_data_d    = DATA_W'(FP_QNAN);
          out_timeout_d = 1'b1;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d   = (state_d == IDLE);
    core_start_d = (state_d == START);
    out_valid_d  = (state_d == OUT);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      in_ready_q    <= 1'b0;
      core_start_q  <= 1'b0;
      out_valid_q   <= 1'b0;
      out_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      core_data_q   <= '0;
      out_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      core_start_q  <= core_start_d;
      out_valid_q   <= out_valid_d;
      out_timeout_q <= out_timeout_d;
      busy_q        <= busy_d;
      core_data_q   <= core_data_d;
      out_data_q    <= out_data_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.core_start  = core_start_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_timeout = out_timeout_q;
  assign bus.busy        = busy_q;
  assign bus.core_data   = core_data_q;
  assign bus.out_data    = out_data_q;

endmodule

// File: tb/tb_fp_job_sequencer.sv
// tb_fp_job_sequencer: directed + random bench with a job-timeline model.
// Timeout checks are active when FP_SEQ_TIMEOUT_EN is defined.
module tb_fp_job_sequencer;

  localparam int TO = 8;
`ifdef FP_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   starts = 0;

  always #5 clk = ~clk;

  fp_seq_if #(.DATA_W(32)) bus ();

  fp_job_sequencer #(
    .DATA_W  (32),
    .TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  // Model: a job is a timeline counted in edges since its accept edge.
  bit          m_act = 0, m_res = 0, m_rdy = 0, m_to = 0;
  int          m_t = 0;
  logic [31:0] m_cd = 0, m_od = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 0; m_res = 0; m_rdy = 0; m_to = 0;
      m_t = 0; m_cd = 0; m_od = 0;
    end else if (!m_act) begin
      if (bus.in_valid && m_rdy) begin
        m_act = 1; m_t = 0; m_res = 0;
        m_cd = bus.in_data;
      end
      m_rdy = !m_act;
    end else begin
      m_t++;
      if (m_res) begin
        if (bus.out_ready) begin
          m_act = 0; m_rdy = 1;
        end
      end else if (m_t >= 3) begin
        if (bus.core_done) begin
          m_res = 1; m_od = bus.core_result; m_to = 0;
        end else if (TO_EN && (m_t - 3 == TO - 1)) begin
          m_res = 1; m_od = 32'h7FC0_0000; m_to = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bus.core_start === 1'b1) starts++;
    chk("m_in_ready",  bus.in_ready,    m_rdy);
    chk("m_busy",      bus.busy,        m_act);
    chk("m_start",     bus.core_start,  m_act && m_t == 1);
    chk("m_out_valid", bus.out_valid,   m_act && m_res);
    chk("m_core_data", bus.core_data,   m_cd);
    chk("m_out_data",  bus.out_data,    m_od);
    chk("m_timeout",   bus.out_timeout, m_to);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic finish_job();
    int n = 0;
    bus.core_done = 1;
    bus.out_ready = 1;
    do begin
      tick();
      n++;
    end while (bus.in_ready !== 1'b1 && n < 30);
    chk("finish_bound", n < 30, 1);
    bus.core_done = 0;
  endtask

  int s0;
  int mode;

  initial begin
    bus.in_valid = 0; bus.in_data = 0;
    bus.core_done = 0; bus.core_result = 0;
    bus.out_ready = 0;
    #1 rst_n = 0;
    tick(); tick();
    chk("rst_in_ready",  bus.in_ready, 0);
    chk("rst_busy",      bus.busy, 0);
    chk("rst_core_data", bus.core_data, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data",  bus.out_data, 0);
    rst_n = 1;
    tick();
    chk("post_rst_ready", bus.in_ready, 1);

    // basic job
    s0 = starts;
    bus.in_valid = 1; bus.in_data = 32'h437F_0000;
    bus.out_ready = 1;
    tick();
    bus.in_valid = 0;
    chk("b_busy", bus.busy, 1);
    chk("b_ready", bus.in_ready, 0);
    chk("b_cdata", bus.core_data, 32'h437F_0000);
    chk("b_nostart", bus.core_start, 0);
    tick();
    chk("b_start", bus.core_start, 1);
    tick();
    chk("b_start_fall", bus.core_start, 0);
    tick(); tick();
    bus.core_done = 1; bus.core_result = 32'h4120_0000;
    tick();
    bus.core_done = 0;
    chk("b_valid", bus.out_valid, 1);
    chk("b_data", bus.out_data, 32'h4120_0000);
    chk("b_to", bus.out_timeout, 0);
    tick();
    chk("b_idle", bus.in_ready, 1);
    chk("b_pulses", starts - s0, 1);

    // minimum latency, done held high
    bus.core_done = 1; bus.core_result = 32'h3F80_0000;
    bus.in_valid = 1; bus.in_data = 32'h4049_0FDB;
    bus.out_ready = 0;
    tick();
    bus.in_valid = 0;
    tick();
    chk("l_e1_valid", bus.out_valid, 0);
    tick();
    chk("l_e2_valid", bus.out_valid, 0);
    tick();
    chk("l_e3_valid", bus.out_valid, 1);
    chk("l_data", bus.out_data, 32'h3F80_0000);
    bus.out_ready = 1;
    tick();
    bus.core_done = 0;
    chk("l_ready", bus.in_ready, 1);

    // backpressure with second operand held
    bus.out_ready = 0;
    bus.in_valid = 1; bus.in_data = 32'h1111_1111;
    tick();
    bus.in_data = 32'h2222_2222;
    tick(); tick();
    bus.core_done = 1; bus.core_result = 32'hC0A0_0000;
    tick();
    bus.core_done = 0;
    for (int i = 0; i < 10; i++) begin
      chk("bp_ready", bus.in_ready, 0);
      chk("bp_data", bus.out_data, 32'hC0A0_0000);
      tick();
    end
    chk("bp_valid", bus.out_valid, 1);
    bus.out_ready = 1;
    tick();
    chk("bp_hs_ready", bus.in_ready, 1);
    chk("bp_keep_cd", bus.core_data, 32'h1111_1111);
    tick();
    bus.in_valid = 0;
    chk("bp_second", bus.core_data, 32'h2222_2222);
    chk("bp_busy", bus.busy, 1);
    finish_job();

`ifdef FP_SEQ_TIMEOUT_EN
    bus.out_ready = 0; bus.core_done = 0;
    bus.in_valid = 1; bus.in_data = 32'h3;
    tick();
    bus.in_valid = 0;
    repeat (9) tick();
    chk("t_e9_valid", bus.out_valid, 0);
    tick();
    chk("t_valid", bus.out_valid, 1);
    chk("t_nan", bus.out_data, 32'h7FC0_0000);
    chk("t_flag", bus.out_timeout, 1);
    bus.out_ready = 1;
    tick();
    chk("t_ready", bus.in_ready, 1);
    bus.out_ready = 0;
    bus.in_valid = 1; bus.in_data = 32'h4;
    tick();
    bus.in_valid = 0;
    repeat (9) tick();
    bus.core_done = 1; bus.core_result = 32'h40A0_0000;
    tick();
    bus.core_done = 0;
    chk("tv_valid", bus.out_valid, 1);
    chk("tv_data", bus.out_data, 32'h40A0_0000);
    chk("tv_flag", bus.out_timeout, 0);
    bus.out_ready = 1;
    tick();
`endif

    // reset during START
    bus.out_ready = 1; bus.core_done = 0;
    bus.in_valid = 1; bus.in_data = 32'h55;
    tick();
    bus.in_valid = 0;
    tick();
    chk("r_start", bus.core_start, 1);
    rst_n = 0;
    #1;
    chk("r_start_drop", bus.core_start, 0);
    chk("r_busy", bus.busy, 0);
    chk("r_ready", bus.in_ready, 0);
    chk("r_cdata", bus.core_data, 0);
    chk("r_valid", bus.out_valid, 0);
    tick();
    rst_n = 1;
    tick();
    chk("r_ready_rel", bus.in_ready, 1);
    bus.in_valid = 1; bus.in_data = 32'h66;
    tick();
    bus.in_valid = 0;
    bus.core_result = 32'h1234_5678;
    finish_job();
    chk("r_job_data", bus.out_data, 32'h1234_5678);
    chk("r_job_cd", bus.core_data, 32'h66);

    // random traffic against the model
    for (int blk = 0; blk < 12; blk++) begin
      mode = blk % (TO_EN ? 5 : 4);
      for (int c = 0; c < 200; c++) begin
        bus.in_valid = ($urandom % 3) != 0;
        bus.in_data = $urandom;
        bus.core_result = $urandom;
        bus.out_ready = ($urandom % 3) != 0;
        case (mode)
          0: bus.core_done = ($urandom % 4) == 0;
          1: bus.core_done = ($urandom % 2) == 1;
          2: bus.core_done = 1;
          3: bus.core_done = ($urandom % 8) == 0;
          default: bus.core_done = ($urandom % 16) == 0;
        endcase
        if (($urandom % 300) == 0) begin
          rst_n = 0;
          tick();
          rst_n = 1;
        end
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
